// File: rtl/crc8_frame_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_frame_tx_if
//  Description : Bundle of the source stream, CRC-engine side-band and sink
//                stream signals used by crc8_frame_tx. The master modport is
//                the framer's view; the slave modport is the surroundings'
//                view (source, CRC engine, sink).
//  Revision    : 1.0 - initial release
// ============================================================================
interface crc8_frame_tx_if #(
    parameter int CNT_W = 16
) ();

    // Source stream
    logic [7:0]       s_data_i;
    logic             s_valid_i;
    logic             s_last_i;
    logic             s_ready_o;

    // CRC engine side-band
    logic [7:0]       crc_din_o;
    logic             crc_valid_o;
    logic             crc_rd_o;
    logic [7:0]       crc_i;

    // Sink stream
    logic [7:0]       m_data_o;
    logic             m_valid_o;
    logic             m_last_o;
    logic             m_ready_i;

    // Statistics
    logic [CNT_W-1:0] frame_cnt_o;

    modport master (
        input  s_data_i, s_valid_i, s_last_i, crc_i, m_ready_i,
        output s_ready_o, crc_din_o, crc_valid_o, crc_rd_o,
               m_data_o, m_valid_o, m_last_o, frame_cnt_o
    );

    modport slave (
        output s_data_i, s_valid_i, s_last_i, crc_i, m_ready_i,
        input  s_ready_o, crc_din_o, crc_valid_o, crc_rd_o,
               m_data_o, m_valid_o, m_last_o, frame_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/crc8_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_frame_tx
//  Description : Byte-serial framer that feeds each payload byte to an
//                external CRC-8 engine, waits out the engine's busy time,
//                forwards the byte to the sink and, after the final payload
//                byte, appends the CRC byte read back from the engine. The
//                engine is then cleared and the completed-frame counter
//                advanced. One byte is in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc8_frame_tx #(
    parameter int BUSY_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    crc8_frame_tx_if.master   bus
);

    // Wide enough to hold BUSY_CYCLES itself.
    localparam int c_WAIT_W = $clog2(BUSY_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FEED    = 3'd1,
        WAIT    = 3'd2,
        OUT     = 3'd3,
        CRC_OUT = 3'd4,
        CLEAR   = 3'd5,
        DRAIN   = 3'd6
    } state_t;

    state_t              r_state;
    logic [7:0]          r_byte;       // latched payload byte
    logic                r_last;       // latched end-of-frame flag
    logic [c_WAIT_W-1:0] r_wait_cnt;   // engine busy countdown
    logic [7:0]          r_crc_hold;   // CRC captured after the final byte

    logic                r_s_ready;
    logic [7:0]          r_crc_din;
    logic                r_crc_valid;
    logic                r_crc_rd;
    logic [7:0]          r_m_data;
    logic                r_m_valid;
    logic                r_m_last;
    logic [CNT_W-1:0]    r_frame_cnt;

    // Framing FSM; every output is a register updated on the transition
    // into the state that owns it, so outputs are glitch-free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_byte      <= 8'h00;
            r_last      <= 1'b0;
            r_wait_cnt  <= '0;
            r_crc_hold  <= 8'h00;
            r_s_ready   <= 1'b1;
            r_crc_din   <= 8'h00;
            r_crc_valid <= 1'b0;
            r_crc_rd    <= 1'b0;
            r_m_data    <= 8'h00;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // Engine strobes are single-cycle by construction.
            r_crc_valid <= 1'b0;
            r_crc_rd    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.s_valid_i) begin
                        r_byte      <= bus.s_data_i;
                        r_last      <= bus.s_last_i;
                        r_crc_din   <= bus.s_data_i;
                        r_crc_valid <= 1'b1;
                        r_s_ready   <= 1'b0;
                        r_state     <= FEED;
                    end
                end

                FEED: begin
                    r_wait_cnt <= c_WAIT_W'(BUSY_CYCLES);
                    r_state    <= WAIT;
                end

                WAIT: begin
                    if (r_wait_cnt == c_WAIT_W'(1)) begin
                        r_wait_cnt <= '0;
                        // The engine has settled; this is the only point at
                        // which its running CRC is taken.
                        if (r_last) begin
                            r_crc_hold <= bus.crc_i;
                        end
                        r_m_data  <= r_byte;
                        r_m_last  <= 1'b0;
                        r_m_valid <= 1'b1;
                        r_state   <= OUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - c_WAIT_W'(1);
                    end
                end

                OUT: begin
                    if (bus.m_ready_i) begin
                        if (r_last) begin
                            // m_valid stays high straight into the CRC byte.
                            r_m_data <= r_crc_hold;
                            r_m_last <= 1'b1;
                            r_state  <= CRC_OUT;
                        end else begin
                            r_m_valid <= 1'b0;
                            r_s_ready <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end
                end

                CRC_OUT: begin
                    if (bus.m_ready_i) begin
                        r_m_valid   <= 1'b0;
                        r_m_last    <= 1'b0;
                        r_crc_rd    <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        r_state     <= CLEAR;
                    end
                end

                CLEAR: begin
                    r_state <= DRAIN;
                end

                // Idle cycle that lets the engine finish its clear before
                // the next frame's first byte can be fed.
                DRAIN: begin
                    r_s_ready <= 1'b1;
                    r_state   <= IDLE;
                end

                default: begin
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                    r_s_ready <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready_o   = r_s_ready;
    assign bus.crc_din_o   = r_crc_din;
    assign bus.crc_valid_o = r_crc_valid;
    assign bus.crc_rd_o    = r_crc_rd;
    assign bus.m_data_o    = r_m_data;
    assign bus.m_valid_o   = r_m_valid;
    assign bus.m_last_o    = r_m_last;
    assign bus.frame_cnt_o = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_crc8_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc8_frame_tx
//  Description : Directed bench for crc8_frame_tx paired with a CRC-8/MAXIM
//                engine model (reflected poly 0x8C, init 0x00, busy 8 cycles).
//                A second framer with a 2-bit frame counter runs in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc8_frame_tx;

    logic clk;
    logic rst;

    crc8_frame_tx_if #(.CNT_W(16)) ifc  ();
    crc8_frame_tx_if #(.CNT_W(2))  ifc2 ();

    crc8_frame_tx #(.BUSY_CYCLES(8), .CNT_W(16)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    crc8_frame_tx #(.BUSY_CYCLES(8), .CNT_W(2)) u_dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc2)
    );

    assign ifc2.s_data_i  = ifc.s_data_i;
    assign ifc2.s_valid_i = ifc.s_valid_i;
    assign ifc2.s_last_i  = ifc.s_last_i;
    assign ifc2.m_ready_i = ifc.m_ready_i;
    assign ifc2.crc_i     = ifc.crc_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CRC-8/MAXIM engine model
    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
        end
        return r;
    endfunction

    logic [7:0] eng_crc;
    int         eng_busy;
    int         cyc;
    int         n_valid;
    int         n_rd;
    int         pulse_q[$];
    logic [8:0] out_q[$];

    assign ifc.crc_i = eng_crc;

    // Engine model, cycle counter and sink-side monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            eng_crc  <= 8'h00;
            eng_busy <= 0;
        end else begin
            if (ifc.crc_valid_o) begin
                eng_crc  <= crc8_upd(eng_crc, ifc.crc_din_o);
                eng_busy <= 8;
                n_valid  <= n_valid + 1;
                pulse_q.push_back(cyc);
            end else begin
                if (eng_busy != 0) eng_busy <= eng_busy - 1;
                if (ifc.crc_rd_o) eng_crc <= 8'h00;
            end
            if (ifc.crc_rd_o) n_rd <= n_rd + 1;
            if (ifc.m_valid_o && ifc.m_ready_i) out_q.push_back({ifc.m_last_o, ifc.m_data_o});
        end
    end

    // Engine-side protocol: no feed while busy, never feed and clear together
    always @(negedge clk) begin
        if (!rst && ifc.crc_valid_o) begin
            check("engine_busy_at_feed", eng_busy, 0);
            check("valid_rd_overlap", ifc.crc_rd_o, 1'b0);
        end
    end

    logic [7:0] tx_buf  [16];
    logic [8:0] exp_buf [16];

    task automatic send_byte(input logic [7:0] d, input logic l);
        int k;
        ifc.s_data_i  = d;
        ifc.s_last_i  = l;
        ifc.s_valid_i = 1'b1;
        k = 0;
        while (ifc.s_ready_o !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("accept_in_time", (k < 200), 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // s_valid stays high across the whole frame
    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) send_byte(tx_buf[i], (i == n - 1));
        ifc.s_valid_i = 1'b0;
        ifc.s_last_i  = 1'b0;
    endtask

    task automatic wait_rd(input string tag, input int target);
        int k;
        k = 0;
        while (n_rd < target && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(tag, (n_rd >= target), 1'b1);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int n);
        check({tag, "_count"}, out_q.size(), n);
        for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), out_q[i], exp_buf[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},   ifc.s_ready_o,    1'b1);
        check({tag, "_crc_din"},   ifc.crc_din_o,    8'h00);
        check({tag, "_crc_valid"}, ifc.crc_valid_o,  1'b0);
        check({tag, "_crc_rd"},    ifc.crc_rd_o,     1'b0);
        check({tag, "_m_data"},    ifc.m_data_o,     8'h00);
        check({tag, "_m_valid"},   ifc.m_valid_o,    1'b0);
        check({tag, "_m_last"},    ifc.m_last_o,     1'b0);
        check({tag, "_frame_cnt"}, ifc.frame_cnt_o,  16'd0);
        check({tag, "_cnt2"},      ifc2.frame_cnt_o, 2'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.s_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int v0;
        int r0;
        int k;
        logic [1:0] exp_cnt2 [5];
        exp_cnt2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        cyc = 0; n_valid = 0; n_rd = 0;
        rst = 1'b1;
        ifc.s_data_i = 8'h00; ifc.s_valid_i = 1'b0; ifc.s_last_i = 1'b0; ifc.m_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0x01 -> 0x01, 0x5E
        ifc.m_ready_i = 1'b1;
        out_q.delete();
        v0 = n_valid; r0 = n_rd;
        tx_buf[0] = 8'h01;
        send_frame(1);
        wait_rd("t1_done", r0 + 1);
        exp_buf[0] = {1'b0, 8'h01};
        exp_buf[1] = {1'b1, 8'h5E};
        check_out("t1_out", 2);
        check("t1_valid_pulses", n_valid - v0, 1);
        check("t1_rd_pulses", n_rd - r0, 1);
        check("t1_frame_cnt", ifc.frame_cnt_o, 16'd1);

        // "123456789" -> payload then 0xA1; 10 idle cycles between feeds
        out_q.delete();
        pulse_q.delete();
        r0 = n_rd;
        for (int i = 0; i < 9; i++) begin
            tx_buf[i]  = 8'h31 + 8'(i);
            exp_buf[i] = {1'b0, 8'h31 + 8'(i)};
        end
        exp_buf[9] = {1'b1, 8'hA1};
        send_frame(9);
        wait_rd("t2_done", r0 + 1);
        check_out("t2_out", 10);
        check("t2_pulses", pulse_q.size(), 9);
        for (int i = 1; i < 9; i++) check($sformatf("t2_gap[%0d]", i), pulse_q[i] - pulse_q[i-1] - 1, 10);
        check("t2_frame_cnt", ifc.frame_cnt_o, 16'd2);

        // Sink stalls in OUT and in CRC_OUT
        ifc.m_ready_i = 1'b0;
        out_q.delete();
        v0 = n_valid; r0 = n_rd;
        tx_buf[0] = 8'h01;
        send_frame(1);
        k = 0;
        while (ifc.m_valid_o !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t3_m_valid_seen", (k < 50), 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t3_out_data",  ifc.m_data_o,  8'h01);
            check("t3_out_valid", ifc.m_valid_o, 1'b1);
            check("t3_out_last",  ifc.m_last_o,  1'b0);
            check("t3_out_sready", ifc.s_ready_o, 1'b0);
            @(negedge clk);
        end
        ifc.m_ready_i = 1'b1;
        @(negedge clk);
        ifc.m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_crc_data",  ifc.m_data_o,  8'h5E);
            check("t3_crc_valid", ifc.m_valid_o, 1'b1);
            check("t3_crc_last",  ifc.m_last_o,  1'b1);
            check("t3_crc_sready", ifc.s_ready_o, 1'b0);
            @(negedge clk);
        end
        check("t3_valid_pulses", n_valid - v0, 1);
        check("t3_rd_during_stall", n_rd - r0, 0);
        ifc.m_ready_i = 1'b1;
        wait_rd("t3_done", r0 + 1);
        exp_buf[0] = {1'b0, 8'h01};
        exp_buf[1] = {1'b1, 8'h5E};
        check_out("t3_out", 2);
        check("t3_frame_cnt", ifc.frame_cnt_o, 16'd3);

        // Back-to-back {0x01},{0x01}: engine cleared between frames
        do_reset();
        out_q.delete();
        r0 = n_rd;
        tx_buf[0] = 8'h01;
        send_frame(1);
        send_frame(1);
        wait_rd("t4_done", r0 + 2);
        exp_buf[0] = {1'b0, 8'h01};
        exp_buf[1] = {1'b1, 8'h5E};
        exp_buf[2] = {1'b0, 8'h01};
        exp_buf[3] = {1'b1, 8'h5E};
        check_out("t4_out", 4);
        check("t4_frame_cnt", ifc.frame_cnt_o, 16'd2);

        // Reset in WAIT of byte 3 of a 5-byte frame, then {0x01}
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        ifc.s_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        check_reset_outputs("t5_rst");
        out_q.delete();
        r0 = n_rd;
        repeat (3) @(negedge clk);
        check("t5_no_output_after_rst", out_q.size(), 0);
        tx_buf[0] = 8'h01;
        send_frame(1);
        wait_rd("t5_done", r0 + 1);
        exp_buf[0] = {1'b0, 8'h01};
        exp_buf[1] = {1'b1, 8'h5E};
        check_out("t5_out", 2);
        check("t5_frame_cnt", ifc.frame_cnt_o, 16'd1);

        // 2-bit counter wraps: 1,2,3,0,1
        do_reset();
        for (int i = 0; i < 5; i++) begin
            r0 = n_rd;
            tx_buf[0] = 8'hA0 + 8'(i);
            send_frame(1);
            wait_rd($sformatf("t6_done[%0d]", i), r0 + 1);
            check($sformatf("t6_cnt2[%0d]", i), ifc2.frame_cnt_o, exp_cnt2[i]);
            check($sformatf("t6_cnt16[%0d]", i), ifc.frame_cnt_o, 16'(i + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
